right_line_writer: RTL and testbench
====================================

Name: right_line_writer

Overview:
- Write-side controller for the right-image line buffer BRAM (port A).
- Accepts a pixel stream over a valid/ready handshake and writes one line of LINE_LEN pixels to consecutive addresses starting at 0.
- On a complete line, pulses rea to start the port-B read sweep, then stalls the stream until the reader reports completion on rd_busy. The buffer is therefore never overwritten while it is being read.

Parameters:
- LINE_LEN, 704, pixels per line; the reader sweeps addresses up to 643+15*4=703.
- AW, 10, address width; LINE_LEN <= 2**AW.
- DW, 8, pixel width.

Ports:
- clock  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous active-low reset.
- pix_in  in  DW  incoming right-camera pixel.
- pix_valid  in  1  pix_in valid this cycle.
- pix_ready  out  1  writer accepts pix_in this cycle.
- line_sync  in  1  start-of-line strobe, coincident with the first pixel of a line.
- rd_busy  in  1  reader sweep in progress.
- addra  out  AW  BRAM port-A write address.
- dina  out  DW  BRAM port-A write data.
- wea  out  1  BRAM port-A write enable.
- rea  out  1  one-cycle start pulse to the reader.
- line_err  out  1  sticky: a line_sync arrived mid-line; cleared only by reset.

Behaviour:
- Reset (resetn=0 at posedge): state=FILL, wr_cnt=0, addra=0, dina=0, wea=0, rea=0, pix_ready=0, line_err=0. Reset mid-line discards the partial line. Reset during WAIT_ACK or WAIT_DONE abandons the handoff and does not wait for rd_busy.
- Accept condition: acc = pix_valid & pix_ready.
- pix_ready is registered:
  - 1 in FILL, except the cycle in which the final pixel is accepted; it drops the next cycle.
  - 0 in HANDOFF, WAIT_ACK and WAIT_DONE.
- Write path, 1-cycle latency: on acc, next cycle addra=wr_cnt, dina=pix_in, wea=1. Otherwise wea=0 and addra/dina hold.
- FSM:
  - FILL:
    - On acc, wr_cnt increments.
    - When acc with wr_cnt==LINE_LEN-1: wr_cnt<=0, go to HANDOFF.
    - Pixels with pix_valid=1 before the first line_sync are accepted normally. There is no sync-lock requirement.
  - HANDOFF: one cycle. rea=1 is registered, so rea is high exactly the cycle after the final write (wea=1 at addr LINE_LEN-1) appears. Go to WAIT_ACK.
  - WAIT_ACK: wait for rd_busy=1, then go to WAIT_DONE. If rd_busy is already 1 on entry, leave after one cycle.
  - WAIT_DONE: wait for rd_busy=0, then go to FILL with pix_ready=1 the following cycle.
- line_sync handling:
  - In FILL with acc & line_sync & wr_cnt!=0: the partial line is discarded. This pixel is written at address 0, wr_cnt<=1, line_err<=1.
  - line_sync with wr_cnt==0 is normal.
  - line_sync outside FILL is ignored, because pix_ready=0 so nothing is accepted.
- Simultaneous line_sync and final pixel (wr_cnt==LINE_LEN-1, line_sync=1): the restart rule wins. No handoff; the pixel goes to address 0.
- rea never pulses twice per line and never while in WAIT_DONE.
- Width rules: wr_cnt is AW bits. The compare uses LINE_LEN-1 truncated to AW. No wrap beyond LINE_LEN-1.

Test Plan:
- Reset, then stream 704 pixels with value=addr[7:0] and pix_valid constantly high -> 704 writes, addra 0..703 in order, dina matches; rea high one cycle, the cycle after the addr-703 write; pix_ready=0 from that point.
- After rea, hold rd_busy=0 for 5 cycles, then 1 for 100 cycles, then 0 -> no pix_ready until the cycle after rd_busy falls; second line writes again from addr 0.
- Random pix_valid gaps (~50% duty) over a full line -> exactly 704 writes, no duplicate or skipped addresses, wea only on accepted cycles.
- line_sync on pixel 300 of a line -> line_err=1 and stays 1; that pixel written at addr 0; rea only after 703 further pixels.
- line_sync coincident with pixel 703 -> no rea, write at addr 0, wr_cnt=1.
- resetn low for one cycle during WAIT_DONE while rd_busy=1 -> all outputs at reset values; state FILL with pix_ready=1 the cycle after reset releases, regardless of rd_busy.

Source files
------------

// File: rtl/right_line_writer.sv
// right_line_writer: port-A write controller for the right-image line buffer.
// Fills one line, pulses rea, then holds off the stream until the reader's sweep ends.
`default_nettype none

module right_line_writer #(
  parameter int LINE_LEN = 704,
  parameter int AW       = 10,
  parameter int DW       = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic          line_sync,
  input  logic          rd_busy,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] dina,
  output logic          wea,
  output logic          rea,
  output logic          line_err
);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    HANDOFF   = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST    = AW'(LINE_LEN - 1);
  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] addra_q, addra_d;
  logic [DW-1:0] dina_q, dina_d;
  logic          wea_q, wea_d;
  logic          rea_q, rea_d;
  logic          pix_ready_q, pix_ready_d;
  logic          line_err_q, line_err_d;
  logic          acc;
  logic          restart;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    addra_d     = addra_q;
    dina_d      = dina_q;
    wea_d       = 1'b0;
    rea_d       = 1'b0;
    pix_ready_d = pix_ready_q;
    line_err_d  = line_err_q;

    acc     = pix_valid & pix_ready_q;
    // A mid-line sync restarts the line; the sync pixel itself becomes pixel 0.
    restart = line_sync & (wr_cnt_q != '0);

    if (acc) begin
      wea_d   = 1'b1;
      dina_d  = pix_in;
      addra_d = restart ? '0 : wr_cnt_q;
    end

    case (state_q)
      FILL: begin
        pix_ready_d = 1'b1;
        if (acc) begin
          if (restart) begin
            wr_cnt_d   = CNT_ONE;
            line_err_d = 1'b1;
          end else if (wr_cnt_q == LAST) begin
            wr_cnt_d    = '0;
            pix_ready_d = 1'b0;
            state_d     = HANDOFF;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
          end
        end
      end
      HANDOFF: begin
        rea_d       = 1'b1;
        pix_ready_d = 1'b0;
        state_d     = WAIT_ACK;
      end
      WAIT_ACK: begin
        pix_ready_d = 1'b0;
        if (rd_busy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        pix_ready_d = ~rd_busy;
        if (!rd_busy) state_d = FILL;
      end
      default: begin
        pix_ready_d = 1'b0;
        state_d     = FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= FILL;
      wr_cnt_q    <= '0;
      addra_q     <= '0;
      dina_q      <= '0;
      wea_q       <= 1'b0;
      rea_q       <= 1'b0;
      pix_ready_q <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      wea_q       <= wea_d;
      rea_q       <= rea_d;
      pix_ready_q <= pix_ready_d;
      line_err_q  <= line_err_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign wea       = wea_q;
  assign rea       = rea_q;
  assign line_err  = line_err_q;

endmodule

`default_nettype wire

// File: tb/tb_right_line_writer.sv
// tb_right_line_writer: directed self-checking bench for right_line_writer.
`default_nettype none

module tb_right_line_writer;

  localparam int LINE_LEN = 704;
  localparam int AW       = 10;
  localparam int DW       = 8;

  logic          clock = 1'b0;
  logic          resetn;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          line_sync;
  logic          rd_busy;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          wea;
  logic          rea;
  logic          line_err;

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic exp_err      = 1'b0;

  right_line_writer #(.LINE_LEN(LINE_LEN), .AW(AW), .DW(DW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .line_sync(line_sync),
    .rd_busy  (rd_busy),
    .addra    (addra),
    .dina     (dina),
    .wea      (wea),
    .rea      (rea),
    .line_err (line_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One stream cycle: drive, clock, then check the write that should appear.
  task automatic cyc(input logic v, input logic [7:0] d, input logic s,
                     input logic exp_acc, input logic [9:0] exp_addr);
    pix_valid = v;
    pix_in    = d;
    line_sync = s;
    tick();
    check("wea", {31'd0, wea}, {31'd0, exp_acc});
    if (exp_acc) begin
      check("addra", {22'd0, addra}, {22'd0, exp_addr});
      check("dina", {24'd0, dina}, {24'd0, d});
    end
    check("rea_idle", {31'd0, rea}, 32'd0);
    check("line_err", {31'd0, line_err}, {31'd0, exp_err});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, pix_ready}, 32'd0);
    check({tag, "_wea"}, {31'd0, wea}, 32'd0);
    check({tag, "_rea"}, {31'd0, rea}, 32'd0);
    check({tag, "_addra"}, {22'd0, addra}, 32'd0);
    check({tag, "_dina"}, {24'd0, dina}, 32'd0);
    check({tag, "_err"}, {31'd0, line_err}, 32'd0);
  endtask

  initial begin
    int cnt;
    int budget;
    logic v;

    resetn = 1'b0; pix_in = '0; pix_valid = 1'b0; line_sync = 1'b0; rd_busy = 1'b0;
    repeat (3) tick();
    check_reset_outputs("rst");
    resetn = 1'b1;
    tick();
    check("ready_after_rst", {31'd0, pix_ready}, 32'd1);

    // Line 1: continuous stream, data = address.
    for (int i = 0; i < LINE_LEN; i++) begin
      check("ready_fill1", {31'd0, pix_ready}, 32'd1);
      cyc(1'b1, 8'(i), (i == 0), 1'b1, 10'(i));
    end
    check("ready_drop1", {31'd0, pix_ready}, 32'd0);
    pix_valid = 1'b1;
    tick();
    check("rea_pulse1", {31'd0, rea}, 32'd1);
    check("no_wea_handoff1", {31'd0, wea}, 32'd0);
    check("ready_handoff1", {31'd0, pix_ready}, 32'd0);

    // Reader idle 5 cycles, busy 100, then done.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'hAA, 1'b0, 1'b0, 10'd0);
      check("ready_wait_ack", {31'd0, pix_ready}, 32'd0);
    end
    rd_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 8'hBB, 1'b0, 1'b0, 10'd0);
      check("ready_wait_done", {31'd0, pix_ready}, 32'd0);
    end
    rd_busy = 1'b0;
    cyc(1'b1, 8'hCC, 1'b0, 1'b0, 10'd0);
    check("ready_after_done", {31'd0, pix_ready}, 32'd1);

    // Line 2: random valid gaps; every accepted pixel lands at the next address.
    cnt = 0;
    budget = 0;
    while (cnt < LINE_LEN && budget < 6000) begin
      v = 1'($urandom_range(0, 1));
      check("ready_fill2", {31'd0, pix_ready}, 32'd1);
      cyc(v, 8'(cnt) ^ 8'h5A, v && (cnt == 0), v, 10'(cnt));
      if (v) cnt++;
      budget++;
    end
    check("line2_complete", cnt, LINE_LEN);
    check("ready_drop2", {31'd0, pix_ready}, 32'd0);
    pix_valid = 1'b0;
    tick();
    check("rea_pulse2", {31'd0, rea}, 32'd1);
    rd_busy = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    check("ready_busy2", {31'd0, pix_ready}, 32'd0);
    rd_busy = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    check("ready_done2", {31'd0, pix_ready}, 32'd1);

    // Line 3: sync on pixel 300 restarts the line and sets the sticky error.
    for (int i = 0; i < 300; i++) cyc(1'b1, 8'(i), (i == 0), 1'b1, 10'(i));
    exp_err = 1'b1;
    cyc(1'b1, 8'hE7, 1'b1, 1'b1, 10'd0);
    for (int i = 1; i < LINE_LEN; i++) begin
      check("ready_fill3", {31'd0, pix_ready}, 32'd1);
      cyc(1'b1, 8'(i + 3), 1'b0, 1'b1, 10'(i));
    end
    pix_valid = 1'b0;
    tick();
    check("rea_pulse3", {31'd0, rea}, 32'd1);
    check("err_sticky3", {31'd0, line_err}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    check("ready_wait3", {31'd0, pix_ready}, 32'd0);
    rd_busy = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    rd_busy = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    check("ready_done3", {31'd0, pix_ready}, 32'd1);

    // Line 4: sync coincident with the final pixel wins over the handoff.
    for (int i = 0; i < LINE_LEN - 1; i++) cyc(1'b1, 8'(i), (i == 0), 1'b1, 10'(i));
    cyc(1'b1, 8'h3C, 1'b1, 1'b1, 10'd0);
    check("ready_no_handoff", {31'd0, pix_ready}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    check("ready_still4", {31'd0, pix_ready}, 32'd1);
    for (int i = 1; i < LINE_LEN; i++) cyc(1'b1, 8'(i * 7), 1'b0, 1'b1, 10'(i));
    pix_valid = 1'b0;
    tick();
    check("rea_pulse4", {31'd0, rea}, 32'd1);
    rd_busy = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    check("ready_busy4", {31'd0, pix_ready}, 32'd0);

    // Reset while the reader is still busy abandons the handoff.
    resetn = 1'b0;
    tick();
    exp_err = 1'b0;
    check_reset_outputs("rst_mid");
    resetn = 1'b1;
    tick();
    check("ready_post_rst", {31'd0, pix_ready}, 32'd1);
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 10'd0);
    cyc(1'b1, 8'h98, 1'b0, 1'b1, 10'd1);
    rd_busy = 1'b0;
    pix_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
